// File: rtl/uram_cmd_arbiter.sv
// Round-robin sharing of the URAM lookup controller's find/add/del port between
// NUM_REQ requesters: one command in flight, completion tracking with timeout, tagged response.
module uram_cmd_arbiter #(
    parameter  int NUM_REQ  = 4,
    parameter  int KEY_W    = 29,
    parameter  int TIMEOUT  = 1024,
    parameter  int ERRCNT_W = 16,
    localparam int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [2*NUM_REQ-1:0]     req_op,
    input  logic [KEY_W*NUM_REQ-1:0] req_key,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     uram_find,
    output logic                     uram_add,
    output logic                     uram_del,
    output logic [KEY_W-1:0]         uram_key,
    input  logic                     uram_busy,
    input  logic                     uram_find_ok,
    input  logic                     uram_find_ko,
    output logic                     resp_valid,
    output logic [ID_W-1:0]          resp_id,
    output logic [1:0]               resp_status,
    input  logic                     resp_ready,
    output logic [ERRCNT_W-1:0]      timeout_cnt
);
    localparam int TMR_W = $clog2(TIMEOUT) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_FIND = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_DEL  = 2'b11;

    localparam logic [1:0] ST_DONE = 2'b00;
    localparam logic [1:0] ST_HIT  = 2'b01;
    localparam logic [1:0] ST_MISS = 2'b10;
    localparam logic [1:0] ST_TMO  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_SETTLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [1:0]          op_q, op_d;
    logic [KEY_W-1:0]    key_q, key_d;
    logic                find_q, find_d;
    logic                add_q, add_d;
    logic                del_q, del_d;
    logic                resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]     resp_id_q, resp_id_d;
    logic [1:0]          resp_status_q, resp_status_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [ERRCNT_W-1:0] tocnt_q, tocnt_d;

    logic                gnt_vld;
    logic [ID_W-1:0]     gnt_idx;
    logic                hi_vld;
    logic [ID_W-1:0]     hi_idx;
    logic [ID_W-1:0]     lo_idx;
    logic [1:0]          sel_op;
    logic [KEY_W-1:0]    sel_key;
    logic [TMR_W-1:0]    timer_inc;
    logic                cmd_done;

    // Two priority scans: lowest valid at/after rr_ptr, else lowest valid overall (wrap).
    always_comb begin
        gnt_vld = 1'b0;
        hi_vld  = 1'b0;
        hi_idx  = '0;
        lo_idx  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                gnt_vld = 1'b1;
                lo_idx  = ID_W'(i);
            end
            if (req_valid[i] && (ID_W'(i) >= rr_ptr_q)) begin
                hi_vld = 1'b1;
                hi_idx = ID_W'(i);
            end
        end
        gnt_idx = hi_vld ? hi_idx : lo_idx;
    end

    always_comb begin
        sel_op  = '0;
        sel_key = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == gnt_idx) begin
                sel_op  = req_op[2*i +: 2];
                sel_key = req_key[KEY_W*i +: KEY_W];
            end
        end
    end

    // Ready is only offered from IDLE, and never while reset is held.
    always_comb begin
        req_ready = '0;
        if ((state_q == S_IDLE) && gnt_vld && !rst) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign timer_inc = (timer_q == '1) ? timer_q : timer_q + TMR_W'(1);
    assign cmd_done  = !uram_busy && ((op_q != OP_FIND) || uram_find_ok || uram_find_ko);

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        op_d          = op_q;
        key_d         = key_q;
        find_d        = 1'b0;
        add_d         = 1'b0;
        del_d         = 1'b0;
        resp_valid_d  = resp_valid_q;
        resp_id_d     = resp_id_q;
        resp_status_d = resp_status_q;
        timer_d       = timer_q;
        tocnt_d       = tocnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (gnt_vld) begin
                    rr_ptr_d  = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
                    op_d      = sel_op;
                    resp_id_d = gnt_idx;
                    if (sel_op == OP_NOP) begin
                        state_d       = S_RESP;
                        resp_valid_d  = 1'b1;
                        resp_status_d = ST_DONE;
                    end else begin
                        state_d = S_ISSUE;
                        key_d   = sel_key;
                        timer_d = '0;
                        find_d  = (sel_op == OP_FIND);
                        add_d   = (sel_op == OP_ADD);
                        del_d   = (sel_op == OP_DEL);
                    end
                end
            end
            S_ISSUE: begin
                timer_d = timer_inc;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                timer_d = timer_inc;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_inc;
                // A completion seen on the last allowed cycle still beats the timeout.
                if (cmd_done) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    if (op_q != OP_FIND)  resp_status_d = ST_DONE;
                    else if (uram_find_ok) resp_status_d = ST_HIT;
                    else                   resp_status_d = ST_MISS;
                end else if (timer_q >= TMR_LAST) begin
                    state_d       = S_RESP;
                    resp_valid_d  = 1'b1;
                    resp_status_d = ST_TMO;
                    if (tocnt_q != '1) tocnt_d = tocnt_q + ERRCNT_W'(1);
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            op_q          <= '0;
            key_q         <= '0;
            find_q        <= 1'b0;
            add_q         <= 1'b0;
            del_q         <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= '0;
            resp_status_q <= '0;
            timer_q       <= '0;
            tocnt_q       <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            op_q          <= op_d;
            key_q         <= key_d;
            find_q        <= find_d;
            add_q         <= add_d;
            del_q         <= del_d;
            resp_valid_q  <= resp_valid_d;
            resp_id_q     <= resp_id_d;
            resp_status_q <= resp_status_d;
            timer_q       <= timer_d;
            tocnt_q       <= tocnt_d;
        end
    end

    assign uram_find   = find_q;
    assign uram_add    = add_q;
    assign uram_del    = del_q;
    assign uram_key    = key_q;
    assign resp_valid  = resp_valid_q;
    assign resp_id     = resp_id_q;
    assign resp_status = resp_status_q;
    assign timeout_cnt = tocnt_q;

endmodule

// File: tb/tb_uram_cmd_arbiter.sv
// Bench for uram_cmd_arbiter: transaction-level model (cycle offset since accept) plus
// an emulated URAM controller; directed scenarios followed by a randomized run.
module tb_uram_cmd_arbiter;
    localparam int NR  = 4;
    localparam int KW  = 29;
    localparam int TMO = 16;
    localparam int EW  = 2;
    localparam int IW  = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req_valid;
    logic [2*NR-1:0] req_op;
    logic [KW*NR-1:0] req_key;
    logic [NR-1:0]   req_ready;
    logic            uram_find, uram_add, uram_del;
    logic [KW-1:0]   uram_key;
    logic            uram_busy, uram_find_ok, uram_find_ko;
    logic            resp_valid;
    logic [IW-1:0]   resp_id;
    logic [1:0]      resp_status;
    logic            resp_ready;
    logic [EW-1:0]   timeout_cnt;

    uram_cmd_arbiter #(.NUM_REQ(NR), .KEY_W(KW), .TIMEOUT(TMO), .ERRCNT_W(EW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_op(req_op), .req_key(req_key), .req_ready(req_ready),
        .uram_find(uram_find), .uram_add(uram_add), .uram_del(uram_del), .uram_key(uram_key),
        .uram_busy(uram_busy), .uram_find_ok(uram_find_ok), .uram_find_ko(uram_find_ko),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_status(resp_status),
        .resp_ready(resp_ready), .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // requesters
    bit          pv[NR];
    logic [1:0]  pop[NR];
    logic [KW-1:0] pkey[NR];
    bit gen_en = 0;
    bit refill = 0;
    int skip = -1;
    int rmode = 1;

    // model of the command in flight; c = cycles since accept
    bit          infl = 0;
    int          c = 0;
    int          done = 0;
    logic [1:0]  m_op = '0;
    logic [KW-1:0] m_key = '0;
    int          m_id = 0;
    logic [1:0]  m_st = '0;
    int          ptr = 0;
    int          tocnt = 0;

    // emulated URAM controller plan
    int L = 0;
    bit pok = 0, pko = 0;
    bit f_en = 0;
    int f_L = 1;
    bit f_ok = 0, f_ko = 0;

    // observations of the DUT for literal checks
    int obs_rc = -1, obs_st = 0, obs_id = 0, obs_strb = 0, obs_rv = 0;
    logic [KW-1:0] obs_key = '0;
    int gnt_log[$];
    int exp_g[8] = '{0, 1, 2, 3, 0, 2, 3, 0};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int m_grant();
        for (int k = 0; k < NR; k++) begin
            if (pv[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    task automatic compare();
        logic [NR-1:0] er;
        int g;
        er = '0;
        if (!infl) begin
            g = m_grant();
            if (g >= 0) er[g] = 1'b1;
        end
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("uram_find", 64'(uram_find), 64'(infl && c == 1 && m_op == 2'b01));
        chk("uram_add",  64'(uram_add),  64'(infl && c == 1 && m_op == 2'b10));
        chk("uram_del",  64'(uram_del),  64'(infl && c == 1 && m_op == 2'b11));
        if (infl && m_op != 2'b00 && c < done) chk("uram_key", 64'(uram_key), 64'(m_key));
        chk("resp_valid", 64'(resp_valid), 64'(infl && c >= done));
        if (infl && c >= done) begin
            chk("resp_id", 64'(resp_id), 64'(m_id));
            chk("resp_status", 64'(resp_status), 64'(m_st));
        end
        chk("timeout_cnt", 64'(timeout_cnt), 64'(tocnt));
        for (int k = 0; k < NR; k++) if (req_ready[k]) gnt_log.push_back(k);
        if (infl) begin
            if (uram_find | uram_add | uram_del) begin
                obs_strb++;
                obs_key = uram_key;
            end
            if (resp_valid) begin
                obs_rv++;
                if (obs_rc < 0) begin
                    obs_rc = c;
                    obs_st = int'(resp_status);
                    obs_id = int'(resp_id);
                end
            end
        end
    endtask

    task automatic advance();
        int g, cc;
        if (infl) begin
            if (c >= done && resp_ready) infl = 0;
            else begin
                c++;
                if (c == done && m_st == 2'b11 && tocnt < (1 << EW) - 1) tocnt++;
            end
        end else begin
            g = m_grant();
            if (g >= 0) begin
                infl = 1; c = 1; m_id = g; m_op = pop[g]; m_key = pkey[g];
                pv[g] = 0; ptr = (g + 1) % NR;
                if (f_en) begin
                    L = f_L; pok = f_ok; pko = f_ko;
                end else begin
                    L = ($urandom_range(0, 4) == 0) ? int'($urandom_range(10, 20)) : int'($urandom_range(1, 6));
                    pok = 1'($urandom); pko = 1'($urandom);
                end
                // busy falls at offset 2+L; a find also needs ok or ko to finish
                if (m_op == 2'b00) begin
                    done = 1; m_st = 2'b00;
                end else begin
                    cc = (m_op == 2'b01 && !(pok || pko)) ? 1000000 : 2 + L;
                    if (cc <= TMO) begin
                        done = cc + 1;
                        m_st = (m_op != 2'b01) ? 2'b00 : (pok ? 2'b01 : 2'b10);
                    end else begin
                        done = TMO + 1;
                        m_st = 2'b11;
                    end
                end
                obs_rc = -1; obs_strb = 0; obs_rv = 0;
            end
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            if (!pv[i] && ((gen_en && $urandom_range(0, 3) == 0) || (refill && i != skip))) begin
                pv[i] = 1;
                pop[i] = refill ? 2'b01 : 2'($urandom);
                pkey[i] = KW'($urandom);
            end
            req_valid[i] = pv[i];
            req_op[2*i +: 2] = pv[i] ? pop[i] : 2'($urandom);
            req_key[KW*i +: KW] = pv[i] ? pkey[i] : KW'($urandom);
        end
        case (rmode)
            0:       resp_ready = ($urandom_range(0, 2) != 0);
            1:       resp_ready = 1'b1;
            default: resp_ready = !(infl && c < done + 10);
        endcase
        uram_busy    = infl && c >= 2 && c <= 1 + L;
        uram_find_ok = infl && c >= 2 && pok;
        uram_find_ko = infl && c >= 2 && pko;
    endtask

    task automatic step();
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
        advance();
        drive();
    endtask

    task automatic do_reset(input bit keep, input bit full);
        rst = 1'b1;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_strobes", 64'({uram_find, uram_add, uram_del}), 64'(0));
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        if (full) begin
            chk("rst_uram_key", 64'(uram_key), 64'(0));
            chk("rst_timeout_cnt", 64'(timeout_cnt), 64'(0));
            chk("rst_resp_id_status", 64'({resp_id, resp_status}), 64'(0));
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        infl = 0; ptr = 0; tocnt = 0;
        if (!keep) for (int i = 0; i < NR; i++) pv[i] = 0;
        drive();
    endtask

    task automatic run_cmd(input int id, input logic [1:0] op, input logic [KW-1:0] key,
                           input int l, input bit ok, input bit ko);
        int n;
        pv[id] = 1; pop[id] = op; pkey[id] = key;
        f_en = 1; f_L = l; f_ok = ok; f_ko = ko;
        drive();
        n = 0;
        while (!infl && n < 50) begin step(); n++; end
        while (infl && n < 300) begin step(); n++; end
        if (n >= 300 || !(n > 0)) chk("cmd_bound", 64'(n), 64'(0));
    endtask

    initial begin
        int n;
        for (int i = 0; i < NR; i++) begin
            pv[i] = 1; pop[i] = 2'b01; pkey[i] = KW'($urandom);
        end
        drive();
        do_reset(0, 1);

        // single find, busy for 3 cycles then hit
        run_cmd(0, 2'b01, 29'h123, 3, 1, 0);
        chk("find_resp_cycle", 64'(obs_rc), 64'(6));
        chk("find_status", 64'(obs_st), 64'(1));
        chk("find_id", 64'(obs_id), 64'(0));
        chk("find_strobes", 64'(obs_strb), 64'(1));
        chk("find_key", 64'(obs_key), 64'(29'h123));

        // reset while a command sits in WAIT
        pv[2] = 1; pop[2] = 2'b10; pkey[2] = KW'($urandom);
        f_en = 1; f_L = 30; f_ok = 0; f_ko = 0;
        drive();
        n = 0;
        while (!(infl && c == 5) && n < 100) begin step(); n++; end
        for (int i = 0; i < NR; i++) begin
            pv[i] = 1; pop[i] = 2'b01; pkey[i] = KW'($urandom);
        end
        refill = 1; skip = -1; f_L = 1; f_ok = 1; f_ko = 0; rmode = 1;
        drive();
        #2;
        do_reset(1, 0);

        // round robin, all valid, then requester 1 drops out
        gnt_log.delete();
        n = 0;
        while (gnt_log.size() < 5 && n < 200) begin step(); n++; end
        pv[1] = 0; skip = 1;
        drive();
        while (gnt_log.size() < 8 && n < 400) begin step(); n++; end
        refill = 0;
        for (int i = 0; i < NR; i++) pv[i] = 0;
        drive();
        while (infl && n < 500) begin step(); n++; end
        chk("rr_grant_count", 64'(gnt_log.size() >= 8), 64'(1));
        for (int k = 0; k < 8 && k < gnt_log.size(); k++) chk("rr_grant", 64'(gnt_log[k]), 64'(exp_g[k]));

        // timeouts: find with neither ok nor ko, then stuck-busy adds to saturate the counter
        run_cmd(0, 2'b01, KW'($urandom), 1, 0, 0);
        chk("tmo_resp_cycle", 64'(obs_rc), 64'(17));
        chk("tmo_status", 64'(obs_st), 64'(3));
        chk("tmo_cnt_one", 64'(timeout_cnt), 64'(1));
        for (int k = 0; k < 4; k++) run_cmd(0, 2'b10, KW'($urandom), 30, 0, 0);
        chk("tmo_cnt_sat", 64'(timeout_cnt), 64'(3));

        // backpressure with bystanders waiting
        pv[2] = 1; pop[2] = 2'b01; pkey[2] = KW'($urandom);
        pv[3] = 1; pop[3] = 2'b11; pkey[3] = KW'($urandom);
        rmode = 2;
        run_cmd(1, 2'b01, KW'($urandom), 2, 0, 1);
        chk("bp_resp_cycle", 64'(obs_rc), 64'(5));
        chk("bp_valid_cycles", 64'(obs_rv), 64'(11));
        chk("bp_status", 64'(obs_st), 64'(2));
        rmode = 1; f_L = 1; f_ok = 1; f_ko = 0;
        n = 0;
        while ((infl || pv[2] || pv[3]) && n < 200) begin step(); n++; end

        // nop answers immediately; ok and ko together report a hit
        run_cmd(2, 2'b00, KW'($urandom), 1, 0, 0);
        chk("nop_resp_cycle", 64'(obs_rc), 64'(1));
        chk("nop_status", 64'(obs_st), 64'(0));
        chk("nop_strobes", 64'(obs_strb), 64'(0));
        chk("nop_id", 64'(obs_id), 64'(2));
        run_cmd(0, 2'b01, KW'($urandom), 1, 1, 1);
        chk("okko_status", 64'(obs_st), 64'(1));
        chk("okko_resp_cycle", 64'(obs_rc), 64'(4));

        // randomized traffic
        f_en = 0; gen_en = 1; rmode = 0;
        for (int k = 0; k < 3000; k++) step();
        gen_en = 0; rmode = 1;
        n = 0;
        while ((infl || pv[0] || pv[1] || pv[2] || pv[3]) && n < 2000) begin step(); n++; end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
